// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls bytes from the read side of a byte FIFO and sends each one as an
//   asynchronous UART frame: one start bit, DATA_W data bits LSB first, an
//   optional parity bit, then STOP_BITS stop bits. The line idles high.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   en          in   1 = a new frame may be started
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after a fifo_rd cycle
//   fifo_rd     out  one-cycle read strobe per byte
//   tx          out  serial line
//   busy        out  high whenever the transmitter is not idle
//   byte_done   out  one-cycle pulse in the last clk of the last stop bit
//
// Every output is a flop loaded from the next-state values, so all outputs
// are glitch-free and go to their idle levels as soon as rst falls.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);
    localparam logic             ODD_PAR   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;       // clk count inside the current bit
    logic [IDX_W-1:0]    idx_q, idx_d;       // data bit index, reused for stop bits
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                par_q, par_d;       // running XOR of sent data bits
    logic                tx_q, tx_d;
    logic                fifo_rd_q, fifo_rd_d;
    logic                busy_q, busy_d;
    logic                byte_done_q, byte_done_d;

    logic                bit_end;
    logic                start_ok;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        bit_end  = (cnt_q == CNT_LAST);
        start_ok = en && !fifo_empty;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                // FIFO data became valid on the edge that ended RD.
                shreg_d = fifo_dout;
                par_d   = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = par_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        // Back-to-back frames go straight to RD, giving the
                        // two high clks (RD, CAP) before the next start bit.
                        idx_d   = '0;
                        state_d = start_ok ? S_RD : S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the values the registers are about to
        // take, so the output flops line up with the state flops.
        fifo_rd_d   = (state_d == S_RD);
        busy_d      = (state_d != S_IDLE);
        byte_done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            S_PAR:   tx_d = par_d ^ ODD_PAR;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
            fifo_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
            fifo_rd_q   <= fifo_rd_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Three transmitters at CLKS_PER_BIT=4 run side by side:
//     0: no parity, 1 stop bit      1: even parity, 1 stop bit
//     2: odd parity, 2 stop bits
//   Each has its own FIFO model (dout registered on the read edge) and a
//   reference that expands every popped byte into the expected per-clk line
//   waveform (RD, CAP, start, data, parity, stop) and predicts when the next
//   read strobe must appear from en / FIFO occupancy alone.
module tb_fifo_uart_tx;

    localparam int NI  = 3;
    localparam int CPB = 4;
    localparam logic [NI-1:0] PE_V = 3'b110;
    localparam logic [NI-1:0] PO_V = 3'b100;
    localparam logic [NI-1:0] S2_V = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NI-1:0] tx;
    logic [NI-1:0] busy;
    logic [NI-1:0] fifo_rd;
    logic [NI-1:0] byte_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : gen_cfg
        localparam int PE = PE_V[gi] ? 1 : 0;
        localparam int PO = PO_V[gi] ? 1 : 0;
        localparam int SB = S2_V[gi] ? 2 : 1;

        logic       en         = 1'b0;
        logic       fifo_empty = 1'b1;
        logic [7:0] fifo_dout  = 8'h00;
        logic [7:0] src_mem [256];
        int         src_wr  = 0;
        int         src_rd  = 0;
        logic [1:0] sched [$];      // per clk: {byte_done, tx}
        bit         want_rd = 1'b0;
        int         n_done  = 0;
        int         n_abort = 0;
        bit         fin     = 1'b0;

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .DATA_W      (8),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .fifo_empty(fifo_empty),
            .fifo_dout (fifo_dout),
            .fifo_rd   (fifo_rd[gi]),
            .tx        (tx[gi]),
            .busy      (busy[gi]),
            .byte_done (byte_done[gi])
        );

        task automatic push(input logic [7:0] b);
            src_mem[src_wr % 256] = b;
            src_wr++;
        endtask

        // FIFO model: read data and empty flag registered on the clock edge.
        always @(posedge clk) begin
            if (fifo_rd[gi] && src_rd != src_wr) begin
                fifo_dout  <= src_mem[src_rd % 256];
                src_rd     <= src_rd + 1;
                fifo_empty <= (src_rd + 1 == src_wr);
            end else begin
                fifo_empty <= (src_rd == src_wr);
            end
        end

        // Reference model and per-clk comparison.
        always @(negedge clk) begin
            logic [1:0] e;
            logic [7:0] b;
            if (!rst) begin
                chk($sformatf("rst_tx%0d", gi), tx[gi], 1);
                chk($sformatf("rst_busy%0d", gi), busy[gi], 0);
                chk($sformatf("rst_rd%0d", gi), fifo_rd[gi], 0);
                chk($sformatf("rst_done%0d", gi), byte_done[gi], 0);
                if (sched.size() != 0) n_abort++;
                sched.delete();
                want_rd = 1'b0;
            end else begin
                chk($sformatf("rd%0d", gi), fifo_rd[gi], want_rd);
                if (fifo_rd[gi]) begin
                    chk($sformatf("rd_nonempty%0d", gi), fifo_empty, 0);
                    if (src_rd != src_wr) begin
                        b = src_mem[src_rd % 256];
                        sched.push_back(2'b01);                     // RD
                        sched.push_back(2'b01);                     // CAP
                        repeat (CPB) sched.push_back(2'b00);        // start
                        for (int i = 0; i < 8; i++)
                            repeat (CPB) sched.push_back({1'b0, b[i]});
                        if (PE != 0)
                            repeat (CPB) sched.push_back({1'b0, (^b) ^ (PO != 0)});
                        for (int k = 0; k < SB * CPB; k++)
                            sched.push_back({(k == SB * CPB - 1), 1'b1});
                    end
                end
                if (sched.size() != 0) begin
                    e = sched.pop_front();
                    chk($sformatf("tx%0d", gi), tx[gi], e[0]);
                    chk($sformatf("done%0d", gi), byte_done[gi], e[1]);
                    chk($sformatf("busy%0d", gi), busy[gi], 1);
                    if (e[1]) n_done++;
                end else begin
                    chk($sformatf("idle_tx%0d", gi), tx[gi], 1);
                    chk($sformatf("idle_done%0d", gi), byte_done[gi], 0);
                    chk($sformatf("idle_busy%0d", gi), busy[gi], 0);
                end
                want_rd = (sched.size() == 0) && en && !fifo_empty;
            end
        end

        // Stimulus: directed frames first, then random pushes and en toggling.
        initial begin
            int c;
            wait (rst === 1'b1);
            @(posedge clk);
            #1;
            if (gi == 0) begin
                push(8'hA5);
                en = 1'b1;
                repeat (60) @(posedge clk);
                #1;
                push(8'h00);
                push(8'hFF);
                repeat (120) @(posedge clk);
                #1;
            end else begin
                push(8'h07);
                en = 1'b1;
                repeat (70) @(posedge clk);
                #1;
            end
            for (int it = 0; it < 40; it++) begin
                repeat ($urandom_range(0, 2)) push(8'($urandom_range(0, 255)));
                en = ($urandom_range(0, 3) != 0);
                repeat ($urandom_range(5, 70)) @(posedge clk);
                #1;
            end
            en = 1'b1;
            c = 0;
            while (c < 20000 && (src_rd != src_wr || busy[gi])) begin
                @(posedge clk);
                #1;
                c++;
            end
            chk($sformatf("drain%0d", gi), (src_rd == src_wr) && !busy[gi], 1);
            // Empty FIFO with en high: the line must stay idle.
            repeat (100) @(posedge clk);
            #1;
            chk($sformatf("all_popped%0d", gi), src_rd, src_wr);
            chk($sformatf("frames%0d", gi), n_done + n_abort, src_wr);
            fin = 1'b1;
        end
    end

    initial begin
        bit found;
        bit all_fin;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (200) @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (fifo_rd[0]) found = 1'b1;
        end
        // Twelve clks after RD lands in the data bits of instance 0.
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_tx", tx, {NI{1'b1}});
        chk("async_busy", busy, '0);
        chk("async_rd", fifo_rd, '0);
        chk("async_done", byte_done, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        all_fin = 1'b0;
        for (int c = 0; c < 30000 && !all_fin; c++) begin
            @(posedge clk);
            all_fin = gen_cfg[0].fin && gen_cfg[1].fin && gen_cfg[2].fin;
        end
        chk("finish", all_fin, 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
